hazard_pipe_ctrl: RTL and testbench

- Pipeline-side partner of the hazard unit in the 5-stage RV32I core.
- Owns the PC register, the IF/ID register and the ID/EX register, plus the EX operand-forwarding muxes.
- Consumes the stall, flush and forward controls; returns the rs/rd register fields and the load flag that the hazard unit needs.

---
 rtl/hazard_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// rtl/hazard_pipe_ctrl.sv - PC, IF/ID and ID/EX registers with EX forwarding muxes for the 5-stage RV32I core
// Optional stall/flush event counters: define HAZ_PERF_CNT_EN.
module hazard_pipe_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              CTRL_W    = 12,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  // hazard unit controls
  input  logic              stallf,
  input  logic              stalld,
  input  logic              flushd,
  input  logic              flushe,
  input  logic [1:0]        forwardae,
  input  logic [1:0]        forwardbe,
  // redirect from EX
  input  logic              pcsrce,
  input  logic [XLEN-1:0]   pctargete,
  // fetch / decode inputs
  input  logic [31:0]       instrf,
  input  logic [XLEN-1:0]   rd1d,
  input  logic [XLEN-1:0]   rd2d,
  input  logic [XLEN-1:0]   immextd,
  input  logic [CTRL_W-1:0] ctrld,
  // forward sources
  input  logic [XLEN-1:0]   aluresultm,
  input  logic [XLEN-1:0]   resultw,
  // fetch / decode outputs
  output logic [XLEN-1:0]   pcf,
  output logic [31:0]       instrd,
  output logic [XLEN-1:0]   pcd,
  output logic [4:0]        rs1d,
  output logic [4:0]        rs2d,
  // EX outputs
  output logic [4:0]        rs1e,
  output logic [4:0]        rs2e,
  output logic [4:0]        rde,
  output logic [CTRL_W-1:0] ctrle,
  output logic              resultsrce0,
  output logic [XLEN-1:0]   srcae,
  output logic [XLEN-1:0]   writedatae,
  output logic [XLEN-1:0]   immexte,
  output logic [XLEN-1:0]   pce,
  output logic [XLEN-1:0]   pcplus4e
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Forward select encodings; 2'b11 is reserved and falls back to the register value.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Fetch stage
  logic [XLEN-1:0]   pcf_q, pcf_d;

  // IF/ID register
  logic [31:0]       instrd_q, instrd_d;
  logic [XLEN-1:0]   pcd_q, pcd_d;

  // ID/EX register
  logic [4:0]        rs1e_q, rs1e_d;
  logic [4:0]        rs2e_q, rs2e_d;
  logic [4:0]        rde_q, rde_d;
  logic [XLEN-1:0]   rd1e_q, rd1e_d;
  logic [XLEN-1:0]   rd2e_q, rd2e_d;
  logic [XLEN-1:0]   immexte_q, immexte_d;
  logic [CTRL_W-1:0] ctrle_q, ctrle_d;
  logic [XLEN-1:0]   pce_q, pce_d;
  logic [XLEN-1:0]   pcplus4e_q, pcplus4e_d;

  // Register-field taps from the instruction sitting in decode
  logic [4:0]        rdd;

  // Decode field extraction; combinational so a held IF/ID keeps presenting the same fields.
  always_comb begin
    rs1d = instrd_q[19:15];
    rs2d = instrd_q[24:20];
    rdd  = instrd_q[11:7];
  end

  // Next PC: a redirect beats a fetch stall so a taken branch is never lost.
  always_comb begin
    pcf_d = pcf_q;
    if (pcsrce) begin
      pcf_d = pctargete;
    end else if (!stallf) begin
      pcf_d = pcf_q + PC_STEP;
    end
  end

  // Next IF/ID: flush injects a NOP with a zero PC, stall holds, otherwise capture fetch.
  always_comb begin
    instrd_d = instrd_q;
    pcd_d    = pcd_q;
    if (flushd) begin
      instrd_d = NOP_INSTR;
      pcd_d    = '0;
    end else if (!stalld) begin
      instrd_d = instrf;
      pcd_d    = pcf_q;
    end
  end

  // Next ID/EX: no hold path; a load-use bubble arrives as a flush that zeroes every field.
  always_comb begin
    rs1e_d     = rs1d;
    rs2e_d     = rs2d;
    rde_d      = rdd;
    rd1e_d     = rd1d;
    rd2e_d     = rd2d;
    immexte_d  = immextd;
    ctrle_d    = ctrld;
    pce_d      = pcd_q;
    pcplus4e_d = pcd_q + PC_STEP;
    if (flushe) begin
      rs1e_d     = '0;
      rs2e_d     = '0;
      rde_d      = '0;
      rd1e_d     = '0;
      rd2e_d     = '0;
      immexte_d  = '0;
      ctrle_d    = '0;
      pce_d      = '0;
      pcplus4e_d = '0;
    end
  end

  // Pipeline state update; reset overrides every stall, flush and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q      <= RESET_PC;
      instrd_q   <= NOP_INSTR;
      pcd_q      <= '0;
      rs1e_q     <= '0;
      rs2e_q     <= '0;
      rde_q      <= '0;
      rd1e_q     <= '0;
      rd2e_q     <= '0;
      immexte_q  <= '0;
      ctrle_q    <= '0;
      pce_q      <= '0;
      pcplus4e_q <= '0;
    end else begin
      pcf_q      <= pcf_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      rs1e_q     <= rs1e_d;
      rs2e_q     <= rs2e_d;
      rde_q      <= rde_d;
      rd1e_q     <= rd1e_d;
      rd2e_q     <= rd2e_d;
      immexte_q  <= immexte_d;
      ctrle_q    <= ctrle_d;
      pce_q      <= pce_d;
      pcplus4e_q <= pcplus4e_d;
    end
  end

  // EX operand-A forwarding mux.
  always_comb begin
    case (forwardae)
      FWD_MEM: srcae = aluresultm;
      FWD_WB:  srcae = resultw;
      default: srcae = rd1e_q;
    endcase
  end

  // EX operand-B forwarding mux; its output is also the store data.
  always_comb begin
    case (forwardbe)
      FWD_MEM: writedatae = aluresultm;
      FWD_WB:  writedatae = resultw;
      default: writedatae = rd2e_q;
    endcase
  end

  // Register outputs; ResultSrc[0] tells the hazard unit the EX instruction is a load.
  always_comb begin
    pcf         = pcf_q;
    instrd      = instrd_q;
    pcd         = pcd_q;
    rs1e        = rs1e_q;
    rs2e        = rs2e_q;
    rde         = rde_q;
    ctrle       = ctrle_q;
    resultsrce0 = ctrle_q[1];
    immexte     = immexte_q;
    pce         = pce_q;
    pcplus4e    = pcplus4e_q;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters; a cycle flushing both stages still counts as one flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stalld) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flushd || flushe) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter state, cleared by reset and free to wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Counter outputs.
  always_comb begin
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb/tb_hazard_pipe_ctrl.sv - directed scoreboard bench for hazard_pipe_ctrl
module tb_hazard_pipe_ctrl;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  localparam int S_PCF = 0, S_INSTRD = 1, S_PCD = 2, S_RS1D = 3, S_RS2D = 4;
  localparam int S_RS1E = 5, S_RS2E = 6, S_RDE = 7, S_CTRLE = 8, S_LOAD = 9;
  localparam int S_SRCA = 10, S_WDE = 11, S_PCE = 12, S_PCP4E = 13, S_IMME = 14;
  localparam int S_STALLC = 15, S_FLUSHC = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              stallf, stalld, flushd, flushe, pcsrce;
  logic [1:0]        forwardae, forwardbe;
  logic [XLEN-1:0]   pctargete, rd1d, rd2d, immextd, aluresultm, resultw;
  logic [31:0]       instrf;
  logic [CTRL_W-1:0] ctrld;
  logic [XLEN-1:0]   pcf, pcd, srcae, writedatae, immexte, pce, pcplus4e;
  logic [31:0]       instrd;
  logic [4:0]        rs1d, rs2d, rs1e, rs2e, rde;
  logic [CTRL_W-1:0] ctrle;
  logic              resultsrce0;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]       stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(
    .XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .reset(reset),
    .stallf(stallf), .stalld(stalld), .flushd(flushd), .flushe(flushe),
    .forwardae(forwardae), .forwardbe(forwardbe),
    .pcsrce(pcsrce), .pctargete(pctargete),
    .instrf(instrf), .rd1d(rd1d), .rd2d(rd2d), .immextd(immextd), .ctrld(ctrld),
    .aluresultm(aluresultm), .resultw(resultw),
    .pcf(pcf), .instrd(instrd), .pcd(pcd), .rs1d(rs1d), .rs2d(rs2d),
    .rs1e(rs1e), .rs2e(rs2e), .rde(rde), .ctrle(ctrle), .resultsrce0(resultsrce0),
    .srcae(srcae), .writedatae(writedatae), .immexte(immexte),
    .pce(pce), .pcplus4e(pcplus4e)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_PCF:    return pcf;
      S_INSTRD: return instrd;
      S_PCD:    return pcd;
      S_RS1D:   return 32'(rs1d);
      S_RS2D:   return 32'(rs2d);
      S_RS1E:   return 32'(rs1e);
      S_RS2E:   return 32'(rs2e);
      S_RDE:    return 32'(rde);
      S_CTRLE:  return 32'(ctrle);
      S_LOAD:   return 32'(resultsrce0);
      S_SRCA:   return srcae;
      S_WDE:    return writedatae;
      S_PCE:    return pce;
      S_PCP4E:  return pcplus4e;
      S_IMME:   return immexte;
`ifdef HAZ_PERF_CNT_EN
      S_STALLC: return stall_cnt;
      S_FLUSHC: return flush_cnt;
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic settle();
    #1;
    check_sb();
  endtask

  task automatic clear_hazards();
    stallf = 0; stalld = 0; flushd = 0; flushe = 0; pcsrce = 0;
  endtask

  initial begin
    reset = 1; clear_hazards();
    forwardae = 2'b00; forwardbe = 2'b00;
    pctargete = '0; instrf = 32'h0050_0093;
    rd1d = '0; rd2d = '0; immextd = '0; ctrld = '0;
    aluresultm = '0; resultw = '0;

    // reset state
    expect_v(S_PCF, 32'h0, "rst_pcf");
    expect_v(S_INSTRD, 32'h13, "rst_instrd");
    expect_v(S_PCD, 32'h0, "rst_pcd");
    expect_v(S_RDE, 32'h0, "rst_rde");
    expect_v(S_CTRLE, 32'h0, "rst_ctrle");
    expect_v(S_PCP4E, 32'h0, "rst_pcplus4e");
    expect_v(S_SRCA, 32'h0, "rst_srcae");
    step();

    // free-running fetch of addi x1,x0,5
    reset = 0;
    expect_v(S_PCF, 32'h4, "run_pcf4");
    expect_v(S_INSTRD, 32'h0050_0093, "run_instrd");
    step();
    expect_v(S_PCF, 32'h8, "run_pcf8");
    expect_v(S_RDE, 32'd1, "run_rde");
    expect_v(S_RS1E, 32'd0, "run_rs1e");
    expect_v(S_PCE, 32'h0, "run_pce");
    expect_v(S_PCP4E, 32'h4, "run_pcplus4e");
    step();

    // lw x5 then add x6,x5,x5 with one load-use bubble
    instrf = 32'h0000_2283;
    expect_v(S_PCF, 32'hC, "lw_fetch_pcf");
    step();
    instrf = 32'h0052_8333; ctrld = 12'h003;
    expect_v(S_INSTRD, 32'h0052_8333, "add_in_decode");
    expect_v(S_RDE, 32'd5, "lw_rde");
    expect_v(S_LOAD, 32'd1, "lw_loadflag");
    step();
    stallf = 1; stalld = 1; flushe = 1; ctrld = 12'h001; instrf = 32'h0000_0013;
    expect_v(S_PCF, 32'h10, "lu_pcf_hold");
    expect_v(S_INSTRD, 32'h0052_8333, "lu_instrd_hold");
    expect_v(S_PCD, 32'hC, "lu_pcd_hold");
    expect_v(S_RS1D, 32'd5, "lu_rs1d");
    expect_v(S_RS2D, 32'd5, "lu_rs2d");
    expect_v(S_CTRLE, 32'h0, "lu_bubble_ctrle");
    expect_v(S_RDE, 32'h0, "lu_bubble_rde");
    step();
    clear_hazards(); rd1d = 32'd5; rd2d = 32'd11; immextd = 32'h0000_0123;
    expect_v(S_RDE, 32'd6, "add_rde");
    expect_v(S_RS1E, 32'd5, "add_rs1e");
    expect_v(S_RS2E, 32'd5, "add_rs2e");
    expect_v(S_CTRLE, 32'h1, "add_ctrle");
    expect_v(S_PCE, 32'hC, "add_pce");
    expect_v(S_PCP4E, 32'h10, "add_pcplus4e");
    expect_v(S_IMME, 32'h123, "add_immexte");
    expect_v(S_PCF, 32'h14, "add_pcf");
    step();

    // forwarding muxes (combinational, no clock edge crossed)
    aluresultm = 32'd7; resultw = 32'd9;
    forwardae = 2'b00; forwardbe = 2'b10;
    expect_v(S_SRCA, 32'd5, "fwd_a00"); expect_v(S_WDE, 32'd7, "fwd_b10");
    settle();
    forwardae = 2'b10; forwardbe = 2'b01;
    expect_v(S_SRCA, 32'd7, "fwd_a10"); expect_v(S_WDE, 32'd9, "fwd_b01");
    settle();
    forwardae = 2'b01; forwardbe = 2'b11;
    expect_v(S_SRCA, 32'd9, "fwd_a01"); expect_v(S_WDE, 32'd11, "fwd_b11");
    settle();
    forwardae = 2'b11; forwardbe = 2'b00;
    expect_v(S_SRCA, 32'd5, "fwd_a11"); expect_v(S_WDE, 32'd11, "fwd_b00");
    settle();
    forwardae = 2'b00;

    // taken branch with flushes
    pcsrce = 1; pctargete = 32'h40; flushd = 1; flushe = 1;
    expect_v(S_PCF, 32'h40, "br_pcf");
    expect_v(S_INSTRD, 32'h13, "br_instrd_nop");
    expect_v(S_PCD, 32'h0, "br_pcd");
    expect_v(S_CTRLE, 32'h0, "br_ctrle");
    step();

    // redirect wins over fetch stall
    clear_hazards(); stallf = 1; pcsrce = 1; pctargete = 32'h80; instrf = 32'h0050_0093;
    expect_v(S_PCF, 32'h80, "stallf_redirect_pcf");
    expect_v(S_INSTRD, 32'h0050_0093, "stallf_redirect_instrd");
    expect_v(S_PCD, 32'h40, "stallf_redirect_pcd");
    step();

    // load-use combined with taken branch
    stallf = 1; stalld = 1; flushd = 1; flushe = 1; pcsrce = 1; pctargete = 32'h100;
    expect_v(S_PCF, 32'h100, "lub_pcf");
    expect_v(S_INSTRD, 32'h13, "lub_instrd");
    expect_v(S_PCD, 32'h0, "lub_pcd");
    expect_v(S_CTRLE, 32'h0, "lub_ctrle");
    expect_v(S_RDE, 32'h0, "lub_rde");
    step();

    // reset during stall/flush/redirect
    reset = 1; pctargete = 32'h200;
    expect_v(S_PCF, 32'h0, "rst2_pcf");
    expect_v(S_INSTRD, 32'h13, "rst2_instrd");
    expect_v(S_PCD, 32'h0, "rst2_pcd");
    expect_v(S_RDE, 32'h0, "rst2_rde");
    expect_v(S_CTRLE, 32'h0, "rst2_ctrle");
    expect_v(S_PCE, 32'h0, "rst2_pce");
    expect_v(S_PCP4E, 32'h0, "rst2_pcplus4e");
`ifdef HAZ_PERF_CNT_EN
    expect_v(S_STALLC, 32'h0, "rst2_stall_cnt");
    expect_v(S_FLUSHC, 32'h0, "rst2_flush_cnt");
`endif
    step();

    // PC wrap at the top of the address space
    reset = 0; clear_hazards(); pcsrce = 1; pctargete = 32'hFFFF_FFFC;
    expect_v(S_PCF, 32'hFFFF_FFFC, "wrap_load");
    step();
    pcsrce = 0;
    expect_v(S_PCF, 32'h0, "wrap_pcf");
    expect_v(S_PCD, 32'hFFFF_FFFC, "wrap_pcd");
    step();
    expect_v(S_PCF, 32'h4, "wrap_pcf4");
    expect_v(S_PCE, 32'hFFFF_FFFC, "wrap_pce");
    expect_v(S_PCP4E, 32'h0, "wrap_pcplus4e");
    step();

    // three stall cycles: fetch and decode hold
    stallf = 1; stalld = 1; instrf = 32'h00A0_0113;
    step(); step();
    expect_v(S_PCF, 32'h4, "stall3_pcf");
    expect_v(S_INSTRD, 32'h0050_0093, "stall3_instrd");
`ifdef HAZ_PERF_CNT_EN
    expect_v(S_STALLC, 32'd3, "stall3_cnt");
    expect_v(S_FLUSHC, 32'd0, "stall3_flush_cnt");
`endif
    step();

    // double flush in one cycle
    clear_hazards(); flushd = 1; flushe = 1;
    expect_v(S_INSTRD, 32'h13, "dflush_instrd");
    expect_v(S_PCF, 32'h8, "dflush_pcf");
`ifdef HAZ_PERF_CNT_EN
    expect_v(S_FLUSHC, 32'd1, "dflush_cnt");
`endif
    step();
    clear_hazards();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
